// File: rtl/skinny_output_unloader.sv
// Captures a Skinny-128-384 ciphertext on cipher_done and streams it out
// MSB byte first over a valid/ready handshake.
module skinny_output_unloader #(
  parameter int unsigned DATA_W = 128,
  parameter int unsigned BYTE_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cipher_done,
  input  logic [DATA_W-1:0] ciphertext,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [BYTE_W-1:0] out_byte,
  output logic              out_last,
  output logic              busy,
  output logic              overrun
);

  localparam int unsigned NBEATS = DATA_W / BYTE_W;
  localparam int unsigned CNT_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NBEATS - 1);

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] shreg;
  logic [CNT_W-1:0]  cnt;
  logic              fire;

  assign fire     = out_valid && out_ready;
  // The current beat is always the top of the shift register; after the final
  // shift the register is empty, so the idle byte reads as zero.
  assign out_byte = shreg[DATA_W-1 -: BYTE_W];

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      shreg     <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cipher_done) begin
            state     <= SEND;
            shreg     <= ciphertext;
            cnt       <= '0;
            out_valid <= 1'b1;
            out_last  <= (LAST_CNT == '0);
            busy      <= 1'b1;
          end
        end

        SEND: begin
          if (fire && out_last) begin
            // A new block arriving on the final handshake is chained with no bubble.
            if (cipher_done) begin
              shreg     <= ciphertext;
              cnt       <= '0;
              out_valid <= 1'b1;
              out_last  <= (LAST_CNT == '0);
              busy      <= 1'b1;
            end else begin
              state     <= IDLE;
              shreg     <= shreg << BYTE_W;
              cnt       <= '0;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              busy      <= 1'b0;
            end
          end else begin
            if (fire) begin
              shreg    <= shreg << BYTE_W;
              cnt      <= cnt + 1'b1;
              out_last <= ((cnt + 1'b1) == LAST_CNT);
            end
            if (cipher_done) begin
              overrun <= 1'b1;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_skinny_output_unloader.sv
// Bench for skinny_output_unloader: directed scenarios plus random traffic,
// compared each cycle against a byte-queue reference model.
module tb_skinny_output_unloader;

  localparam int unsigned DATA_W = 128;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned NBEATS = DATA_W / BYTE_W;

  localparam logic [DATA_W-1:0] VEC  = 128'h94ECF589E2017C601B38C6346A10DCFA;
  localparam logic [DATA_W-1:0] ONES = {NBEATS{8'h11}};

  logic              clock = 1'b0;
  logic              reset;
  logic              cipher_done;
  logic [DATA_W-1:0] ciphertext;
  logic              out_ready;
  logic              out_valid;
  logic [BYTE_W-1:0] out_byte;
  logic              out_last;
  logic              busy;
  logic              overrun;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Reference model: bytes still to be delivered for the current block.
  logic [BYTE_W-1:0] exp_q[$];
  logic              exp_overrun;

  skinny_output_unloader #(
    .DATA_W(DATA_W),
    .BYTE_W(BYTE_W)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .cipher_done(cipher_done),
    .ciphertext (ciphertext),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .out_byte   (out_byte),
    .out_last   (out_last),
    .busy       (busy),
    .overrun    (overrun)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load_block(input logic [DATA_W-1:0] ct);
    exp_q.delete();
    for (int unsigned k = 0; k < NBEATS; k++)
      exp_q.push_back(ct[DATA_W-1-k*BYTE_W -: BYTE_W]);
  endtask

  // One clock cycle: apply inputs, check outputs mid-cycle, then advance model.
  task automatic step(input logic d, input logic [DATA_W-1:0] ct, input logic rdy,
                      input logic rst);
    logic m_valid;
    logic m_last;
    logic fired;
    cipher_done = d;
    ciphertext  = d ? ct : {$urandom(), $urandom(), $urandom(), $urandom()};
    out_ready   = rdy;
    reset       = rst;
    @(negedge clock);
    m_valid = (exp_q.size() != 0);
    m_last  = (exp_q.size() == 1);
    check("out_valid", out_valid, m_valid);
    check("out_byte",  out_byte,  m_valid ? exp_q[0] : '0);
    check("out_last",  out_last,  m_last);
    check("busy",      busy,      m_valid);
    check("overrun",   overrun,   exp_overrun);
    @(posedge clock);
    if (rst) begin
      exp_q.delete();
      exp_overrun = 1'b0;
    end else begin
      fired = m_valid && rdy;
      if (fired) void'(exp_q.pop_front());
      if (d) begin
        if (!m_valid || (fired && m_last)) load_block(ct);
        else exp_overrun = 1'b1;
      end
    end
    #1;
  endtask

  task automatic idle(input int unsigned n, input logic rdy);
    for (int unsigned i = 0; i < n; i++) step(1'b0, '0, rdy, 1'b0);
  endtask

  initial begin
    reset       = 1'b1;
    cipher_done = 1'b0;
    ciphertext  = '0;
    out_ready   = 1'b0;
    exp_overrun = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    step(1'b0, '0, 1'b1, 1'b1);
    idle(2, 1'b1);

    // Capture with ready tied high
    step(1'b1, VEC, 1'b1, 1'b0);
    check("first_beat", out_byte, 8'h94);
    idle(NBEATS + 1, 1'b1);
    check("busy_after", busy, 1'b0);

    // Backpressure on beats 0, 7 and 15
    step(1'b1, VEC, 1'b0, 1'b0);
    for (int unsigned k = 0; k < NBEATS; k++) begin
      if (k == 0 || k == 7 || k == 15) idle(3, 1'b0);
      step(1'b0, '0, 1'b1, 1'b0);
    end
    idle(2, 1'b1);

    // Back-to-back blocks chained on the final handshake
    step(1'b1, VEC, 1'b1, 1'b0);
    idle(NBEATS - 1, 1'b1);
    step(1'b1, ONES, 1'b1, 1'b0);
    check("chain_byte", out_byte, 8'h11);
    check("chain_valid", out_valid, 1'b1);
    check("chain_ovr", overrun, 1'b0);
    idle(NBEATS + 1, 1'b1);

    // Overrun: cipher_done at beat 5 is dropped
    step(1'b1, VEC, 1'b1, 1'b0);
    idle(5, 1'b1);
    step(1'b1, ONES, 1'b1, 1'b0);
    idle(NBEATS - 6 + 3, 1'b1);
    check("ovr_sticky", overrun, 1'b1);

    // Reset mid-stream at beat 9, with a coincident cipher_done ignored
    step(1'b1, VEC, 1'b1, 1'b0);
    idle(9, 1'b1);
    step(1'b1, ONES, 1'b1, 1'b1);
    check("rst_valid", out_valid, 1'b0);
    check("rst_ovr", overrun, 1'b0);
    step(1'b1, VEC, 1'b1, 1'b0);
    idle(NBEATS + 1, 1'b1);

    // Idle noise on out_ready
    for (int unsigned i = 0; i < 50; i++) step(1'b0, '0, 1'($urandom()), 1'b0);

    // Random traffic
    for (int unsigned i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 9) == 0),
           {$urandom(), $urandom(), $urandom(), $urandom()},
           ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 299) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
